// File: rtl/seq_divider16by8_pkg.sv
// Purpose : shared state encodings and default widths for the sequential 16/8 divider.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package seq_divider16by8_pkg;

    localparam int DW    = 16;   // dividend / quotient width
    localparam int VW    = 8;    // divisor / remainder width
    localparam int CNT_W = 4;    // iteration counter width, 2**CNT_W == DW

    // Encodings are visible on the state output, so values are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR  = 3'd3
    } state_t;

endpackage

// File: rtl/seq_divider16by8_div_step.sv
// Purpose : one restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency : combinational.
// Backpressure: none.
// Ports: rem (partial remainder, always < divisor), dq_msb (next dividend bit), divisor,
//        rem_next (updated partial remainder), q_bit (quotient bit produced by this step).
module seq_divider16by8_div_step
    import seq_divider16by8_pkg::*;
#(
    parameter int W = VW
) (
    input  logic [W-1:0] rem,
    input  logic         dq_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    // The shifted remainder needs one extra bit before the compare.
    logic [W:0] trial;

    assign trial    = {rem, dq_msb};
    assign q_bit    = (trial >= {1'b0, divisor});
    // After a successful subtract the result is below the divisor, so it fits in W bits.
    assign rem_next = q_bit ? W'(trial - {1'b0, divisor}) : trial[W-1:0];

endmodule

// File: rtl/seq_divider16by8.sv
// Purpose : sequential restoring divider, 16-bit dividend / 8-bit divisor -> quotient + remainder.
// Latency : start accepted at edge N, done_flag high after edge N+16; divide-by-zero flags at edge N.
// Backpressure: start is a level; results are held in DONE/ERR until start is released.
// Ports: clk, rst (async active-high), start, dividend, divisor -> quotient, remainder,
//        done_flag (DONE or ERR), div_by_zero (ERR only), state (FSM encoding for the display).
module seq_divider16by8
    import seq_divider16by8_pkg::*;
#(
    parameter int DW_P    = DW,
    parameter int VW_P    = VW,
    parameter int CNT_W_P = CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW_P-1:0] dividend,
    input  logic [VW_P-1:0] divisor,
    output logic [DW_P-1:0] quotient,
    output logic [VW_P-1:0] remainder,
    output logic            done_flag,
    output logic            div_by_zero,
    output logic [2:0]      state
);

    state_t               st;
    logic [DW_P-1:0]      dq;        // dividend shifting out the top, quotient shifting in the bottom
    logic [VW_P-1:0]      rem_r;
    logic [VW_P-1:0]      divisor_r;
    logic [CNT_W_P-1:0]   cnt;

    logic [VW_P-1:0]      rem_next;
    logic                 q_bit;

    seq_divider16by8_div_step #(
        .W        (VW_P)
    ) u_step (
        .rem      (rem_r),
        .dq_msb   (dq[DW_P-1]),
        .divisor  (divisor_r),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_IDLE;
            dq          <= '0;
            rem_r       <= '0;
            divisor_r   <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done_flag   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            dq        <= dividend;
                            divisor_r <= divisor;
                            rem_r     <= '0;
                            cnt       <= '0;
                            st        <= ST_CALC;
                        end else begin
                            quotient    <= '1;
                            remainder   <= '0;
                            done_flag   <= 1'b1;
                            div_by_zero <= 1'b1;
                            st          <= ST_ERR;
                        end
                    end
                end
                ST_CALC: begin
                    dq    <= {dq[DW_P-2:0], q_bit};
                    rem_r <= rem_next;
                    cnt   <= cnt + 1'b1;
                    // Last iteration: publish the step outputs directly, not the stale registers.
                    if (cnt == CNT_W_P'(DW_P - 1)) begin
                        quotient  <= {dq[DW_P-2:0], q_bit};
                        remainder <= rem_next;
                        done_flag <= 1'b1;
                        st        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Waiting for start to drop keeps a held level from re-triggering.
                    if (!start) begin
                        done_flag <= 1'b0;
                        st        <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (!start) begin
                        done_flag   <= 1'b0;
                        div_by_zero <= 1'b0;
                        st          <= ST_IDLE;
                    end
                end
                default: begin
                    done_flag   <= 1'b0;
                    div_by_zero <= 1'b0;
                    st          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider16by8.sv
module tb_seq_divider16by8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        done_flag;
    logic        div_by_zero;
    logic [2:0]  state;

    seq_divider16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done_flag   (done_flag),
        .div_by_zero (div_by_zero),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every rising edge of done_flag must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            done_prev <= 1'b0;
        end else begin
            if (done_flag && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done_flag), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, "_quotient"},  32'(quotient),    32'(e.q));
                    check({e.name, "_remainder"}, 32'(remainder),   32'(e.r));
                    check({e.name, "_dbz"},       32'(div_by_zero), 32'(e.dbz));
                    check({e.name, "_latency"},   32'(cyc),         32'(e.done_cyc));
                end
            end
            done_prev <= done_flag;
        end
    end

    task automatic wait_cond_done(input string name);
        int n = 0;
        while (!done_flag && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done_flag) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_div(input string name, input logic [15:0] dd, input logic [7:0] dv,
                           input logic [15:0] eq, input logic [7:0] er, input logic ez,
                           input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        e.q = eq; e.r = er; e.dbz = ez; e.name = name;
        // start is sampled on the next edge, which makes cyc equal to cyc+1.
        e.done_cyc = ez ? (cyc + 1) : (cyc + 1 + 16);
        sb_q.push_back(e);
        @(negedge clk);
        wait_cond_done(name);
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({name, "_held_state"}, 32'(state), ez ? 32'd3 : 32'd2);
            check({name, "_held_done"},  32'(done_flag), 32'd1);
        end
        start = 1'b0;
        n = 0;
        @(negedge clk);
        while (state != 3'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_state"}, 32'(state), 32'd0);
        check({name, "_idle_done"},  32'(done_flag), 32'd0);
        check({name, "_kept_q"},     32'(quotient), 32'(eq));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state),       32'd0);
        check("rst_q",     32'(quotient),    32'd0);
        check("rst_r",     32'(remainder),   32'd0);
        check("rst_done",  32'(done_flag),   32'd0);
        check("rst_dbz",   32'(div_by_zero), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_div("d1000_7",   16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 0);
        run_div("d65535_255",16'd65535, 8'd255, 16'd257,   8'd0, 1'b0, 10);
        run_div("d65535_1",  16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 0);
        run_div("d5_9",      16'd5,     8'd9,   16'd0,     8'd5, 1'b0, 0);
        run_div("d0_3",      16'd0,     8'd3,   16'd0,     8'd0, 1'b0, 0);
        run_div("d100_0",    16'd100,   8'd0,   16'hFFFF,  8'd0, 1'b1, 2);

        // Asynchronous reset in the middle of a calculation, after a result is held.
        run_div("d1000_7b",  16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 0);
        @(negedge clk);
        dividend = 16'd40000;
        divisor  = 8'd3;
        start    = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_calc_state", 32'(state), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state),       32'd0);
        check("arst_q",     32'(quotient),    32'd0);
        check("arst_r",     32'(remainder),   32'd0);
        check("arst_done",  32'(done_flag),   32'd0);
        check("arst_dbz",   32'(div_by_zero), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div("d200_13",   16'd200,   8'd13,  16'd15,    8'd5, 1'b0, 0);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
